// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer; CU_ILLEGAL_TRAP_EN traps undefined opcodes into HALT
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [3:0] alu_op,
  output logic       reg_wr,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LDIR   = 3'd2;
  localparam logic [2:0] DECODE = 3'd3;
  localparam logic [2:0] EXEC   = 3'd4;
  localparam logic [2:0] MEM    = 3'd5;
  localparam logic [2:0] WB     = 3'd6;
  localparam logic [2:0] HALT   = 3'd7;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic [2:0] ILL_NXT = HALT;
`else
  localparam logic [2:0] ILL_NXT = FETCH;
`endif
  logic [2:0] st, nxt;
  logic is_nop, is_alu, is_ld, is_st, is_brz, is_jmp, is_halt;
  assign is_nop  = opcode == 6'd0;
  assign is_alu  = opcode >= 6'd1 && opcode <= 6'd5;
  assign is_ld   = opcode == 6'd8;
  assign is_st   = opcode == 6'd9;
  assign is_brz  = opcode == 6'd16;
  assign is_jmp  = opcode == 6'd17;
  assign is_halt = opcode == 6'd63;
  // state register; reset aborts any in-flight access immediately
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nxt;
  // next-state sequencing; opcode is only trusted from DECODE onwards
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = mem_ready ? LDIR : FETCH;
      LDIR:    nxt = DECODE;
      DECODE:  nxt = (is_alu || is_brz || is_jmp) ? EXEC :
                     (is_ld || is_st) ? MEM :
                     is_halt ? HALT :
                     is_nop ? FETCH : ILL_NXT;
      EXEC:    nxt = is_alu ? WB : FETCH;
      MEM:     nxt = !mem_ready ? MEM : is_ld ? WB : FETCH;
      WB:      nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end
`ifdef CU_ILLEGAL_TRAP_EN
  logic ill_q;
  // sticky record of an undefined opcode seen in DECODE
  always_ff @(posedge clk or negedge rst)
    if (!rst) ill_q <= 1'b0;
    else if (st == DECODE && !(is_nop || is_alu || is_ld || is_st || is_brz || is_jmp || is_halt)) ill_q <= 1'b1;
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif
  assign mem_rd  = st == FETCH || (st == MEM && is_ld);
  assign mem_wr  = st == MEM && is_st;
  assign load_ir = st == LDIR;
  assign pc_inc  = st == LDIR;
  assign pc_load = st == EXEC && (is_jmp || (is_brz && alu_zero));
  assign alu_op  = ((st == EXEC || st == WB) && is_alu) ? opcode[3:0] : (st == MEM) ? 4'd1 : 4'd0;
  assign reg_wr  = st == WB;
  assign busy    = st != IDLE && st != HALT;
  assign halted  = st == HALT;
endmodule
